// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO sequencer between EX and external multiplier/divider; DIV_ZERO_FAST_EN enables zero-divisor shortcut.
// Latency: mult stalls MUL_LAT+1 cycles, div 1+divider cycles, mthi/mtlo write next edge with done one cycle later.
// Backpressure: stallreq freezes EX until DONE; flush aborts in-flight work without touching HI/LO.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        stallreq,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic        r_sgn;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_mt_done;
    logic        w_mt_done_nxt;
    logic        w_latch;
    logic        w_hi_we;
    logic        w_lo_we;
    logic [31:0] w_hi_d;
    logic [31:0] w_lo_d;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_mt;
    logic        w_div_zero;

    assign w_is_mul = op_valid && (op[2:1] == 2'b00);
    assign w_is_div = op_valid && (op[2:1] == 2'b01);
    assign w_is_mt  = op_valid && (op[2:1] == 2'b10);

`ifdef DIV_ZERO_FAST_EN
    assign w_div_zero = (src2 == 32'd0);
`else
    assign w_div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_latch       = 1'b0;
        w_hi_we       = 1'b0;
        w_lo_we       = 1'b0;
        w_hi_d        = mul_result[63:32];
        w_lo_d        = mul_result[31:0];
        w_mt_done_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                // flush on the acceptance cycle suppresses everything, mthi/mtlo included
                if (!flush) begin
                    if (w_is_mul) begin
                        w_latch     = 1'b1;
                        w_cnt_nxt   = 4'(MUL_LAT);
                        w_state_nxt = MUL;
                    end else if (w_is_div) begin
                        if (w_div_zero) begin
                            w_hi_we     = 1'b1;
                            w_lo_we     = 1'b1;
                            w_hi_d      = src1;
                            w_lo_d      = 32'hFFFF_FFFF;
                            w_state_nxt = DONE;
                        end else begin
                            w_latch     = 1'b1;
                            w_state_nxt = DIV;
                        end
                    end else if (w_is_mt) begin
                        w_hi_we       = ~op[0];
                        w_lo_we       = op[0];
                        w_hi_d        = src1;
                        w_lo_d        = src1;
                        w_mt_done_nxt = 1'b1;
                    end
                end
            end
            MUL: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_hi_we     = 1'b1;
                    w_lo_we     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DIV: begin
                w_hi_d = div_result[63:32];
                w_lo_d = div_result[31:0];
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (div_ready) begin
                    w_hi_we     = 1'b1;
                    w_lo_we     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // the finished instruction is still on op_valid here; never re-accept it
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= 4'd0;
            r_op1     <= 32'd0;
            r_op2     <= 32'd0;
            r_sgn     <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_mt_done <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_mt_done <= w_mt_done_nxt;
            if (w_latch) begin
                r_op1 <= src1;
                r_op2 <= src2;
                r_sgn <= ~op[0];
            end
            if (w_hi_we) begin
                r_hi <= w_hi_d;
            end
            if (w_lo_we) begin
                r_lo <= w_lo_d;
            end
        end
    end

    // op_valid is raw, so the IDLE stall term is gated to keep outputs quiet in reset
    assign stallreq    = resetn && (((r_state == IDLE) && (w_is_mul || w_is_div)) ||
                                    (r_state == MUL) || (r_state == DIV));
    assign done        = (r_state == DONE) || r_mt_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign mul_signed  = (r_state == MUL) ? r_sgn : 1'b0;
    assign mul_ina     = (r_state == MUL) ? r_op1 : 32'd0;
    assign mul_inb     = (r_state == MUL) ? r_op2 : 32'd0;
    assign div_start   = (r_state == DIV) && !div_ready;
    assign div_annul   = (r_state == DIV) && flush;
    assign div_signed  = (r_state == DIV) ? r_sgn : 1'b0;
    assign div_opdata1 = (r_state == DIV) ? r_op1 : 32'd0;
    assign div_opdata2 = (r_state == DIV) ? r_op2 : 32'd0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: vector table plus hand sequences for flush/reset corners,
// with a behavioural multiplier/divider and a HI/LO scoreboard popped on each done pulse.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        stallreq;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic        div_annul;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic [63:0] div_result;
    logic        div_ready;

    int ntests = 0;
    int nfail  = 0;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
        .src1(src1), .src2(src2), .flush(flush),
        .stallreq(stallreq), .done(done), .hi(hi), .lo(lo),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_result(div_result), .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    // behavioural multiplier: both operands sign- or zero-extended to 64 bits
    always_comb begin
        mul_result = 64'd0;
        if (mul_signed)
            mul_result = {{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb};
        else
            mul_result = {32'd0, mul_ina} * {32'd0, mul_inb};
    end

    logic signed [31:0] dq;
    logic signed [31:0] dr;
    always_comb begin
        div_result = 64'd0;
        dq = 32'sd0;
        dr = 32'sd0;
        if (div_opdata2 == 32'd0) begin
            div_result = {div_opdata1, 32'hFFFF_FFFF};
        end else if (div_signed) begin
            dq = $signed(div_opdata1) / $signed(div_opdata2);
            dr = $signed(div_opdata1) % $signed(div_opdata2);
            div_result = {dr, dq};
        end else begin
            div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
        end
    end

    // divider handshake: ready after div_lat_tb cycles of div_start
    logic [7:0] dcnt;
    logic [7:0] div_lat_tb = 8'd1;
    logic       force_rdy  = 1'b0;
    always @(posedge clk or negedge resetn) begin
        if (!resetn)        dcnt <= 8'd0;
        else if (div_start) dcnt <= dcnt + 8'd1;
        else                dcnt <= 8'd0;
    end
    assign div_ready = force_rdy || (dcnt == div_lat_tb);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [63:0] sb_q[$];
    int pushes     = 0;
    int done_seen  = 0;
    int dstart_cnt = 0;

    always @(negedge clk) begin
        if (div_start) dstart_cnt++;
        if (resetn && done) begin
            done_seen++;
            if (sb_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("hilo", {hi, lo}, sb_q.pop_front());
        end
    end

    task automatic push(input logic [31:0] eh, input logic [31:0] el);
        sb_q.push_back({eh, el});
        pushes++;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [7:0]  dlat;
        int          exp_stall;
        int          exp_dstart;
        bit          exp_done;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    task automatic run_op(input vec_t v);
        int st;
        bit ended;
        st = 0;
        ended = 1'b0;
        @(posedge clk); #1;
        div_lat_tb = v.dlat;
        op_valid = 1'b1; op = v.op; src1 = v.s1; src2 = v.s2;
        dstart_cnt = 0;
        if (v.exp_done) push(v.exp_hi, v.exp_lo);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stallreq) st++;
            else begin
                ended = 1'b1;
                break;
            end
        end
        if (!ended) check("stall_timeout", 64'd1, 64'd0);
        check("stall_cycles", 64'(st), 64'(v.exp_stall));
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("no_restart", {63'd0, stallreq}, 64'd0);
        check("dstart_cycles", 64'(dstart_cnt), 64'(v.exp_dstart));
        if (!v.exp_done) check("noop_hilo", {hi, lo}, {v.exp_hi, v.exp_lo});
    endtask

    vec_t vt[12];
    vec_t vz;

    initial begin
        vt[0]  = '{3'b000, 32'hFFFF_FFFE, 32'd3, 8'd1, 3, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vt[1]  = '{3'b001, 32'hFFFF_FFFE, 32'd3, 8'd1, 3, 0, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA};
        vt[2]  = '{3'b011, 32'd100, 32'd7, 8'd33, 35, 33, 1'b1, 32'd2, 32'd14};
        vt[3]  = '{3'b010, 32'hFFFF_FF9C, 32'd7, 8'd5, 7, 5, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2};
        vt[4]  = '{3'b011, 32'hFFFF_FF9C, 32'd7, 8'd1, 3, 1, 1'b1, 32'd2, 32'h2492_4916};
        vt[5]  = '{3'b100, 32'h1234_5678, 32'd0, 8'd1, 0, 0, 1'b1, 32'h1234_5678, 32'h2492_4916};
        vt[6]  = '{3'b101, 32'd5, 32'd0, 8'd1, 0, 0, 1'b1, 32'h1234_5678, 32'd5};
        vt[7]  = '{3'b110, 32'hAAAA_AAAA, 32'd1, 8'd1, 0, 0, 1'b0, 32'h1234_5678, 32'd5};
        vt[8]  = '{3'b111, 32'hAAAA_AAAA, 32'd1, 8'd1, 0, 0, 1'b0, 32'h1234_5678, 32'd5};
        vt[9]  = '{3'b001, 32'h0001_0000, 32'h0001_0000, 8'd1, 3, 0, 1'b1, 32'd1, 32'd0};
        vt[10] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 8'd1, 3, 0, 1'b1, 32'h4000_0000, 32'd0};
        vt[11] = '{3'b000, 32'd7, 32'hFFFF_FFFD, 8'd1, 3, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};

        resetn = 1'b0; op_valid = 1'b1; op = 3'b000; src1 = 32'd1; src2 = 32'd1; flush = 1'b0;
        #12;
        check("rst_ctrl", {58'd0, stallreq, done, div_start, div_annul, div_signed, mul_signed}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        op_valid = 1'b0;
        @(negedge clk); resetn = 1'b1;

        for (int i = 0; i < 12; i++) run_op(vt[i]);

        // mthi then mtlo on consecutive cycles
        push(32'h1234_5678, 32'hFFFF_FFEB);
        push(32'h1234_5678, 32'd5);
        @(posedge clk); #1; op_valid = 1'b1; op = 3'b100; src1 = 32'h1234_5678;
        @(negedge clk); check("mt_stall0", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1; op = 3'b101; src1 = 32'd5;
        @(negedge clk); check("mt_stall1", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1; op_valid = 1'b0;
        repeat (2) @(negedge clk);

        // flush at DIV cycle 10, then a stray div_ready
        div_lat_tb = 8'd33;
        @(posedge clk); #1; op_valid = 1'b1; op = 3'b010; src1 = 32'd50; src2 = 32'd3;
        repeat (10) @(posedge clk);
        #1; flush = 1'b1;
        @(negedge clk); check("flush_annul", {63'd0, div_annul}, 64'd1);
        @(posedge clk); #1; flush = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        check("flush_idle", {61'd0, stallreq, div_start, div_annul}, 64'd0);
        force_rdy = 1'b1;
        repeat (2) @(negedge clk);
        force_rdy = 1'b0;
        check("flush_hilo", {hi, lo}, {32'h1234_5678, 32'd5});

        // flush on the acceptance cycle
        @(posedge clk); #1; op_valid = 1'b1; op = 3'b000; src1 = 32'd3; src2 = 32'd3; flush = 1'b1;
        @(posedge clk); #1; op_valid = 1'b0; flush = 1'b0;
        @(negedge clk); check("acc_flush_idle", {63'd0, stallreq}, 64'd0);
        repeat (3) @(negedge clk);
        check("acc_flush_hilo", {hi, lo}, {32'h1234_5678, 32'd5});

        // flush coincident with the multiply completion edge
        @(posedge clk); #1; op_valid = 1'b1; op = 3'b001; src1 = 32'd2; src2 = 32'd2;
        @(posedge clk);
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0; op_valid = 1'b0;
        @(negedge clk); check("cmp_flush_idle", {63'd0, stallreq}, 64'd0);
        repeat (3) @(negedge clk);
        check("cmp_flush_hilo", {hi, lo}, {32'h1234_5678, 32'd5});

        // zero divisor
`ifdef DIV_ZERO_FAST_EN
        vz = '{3'b010, 32'd9, 32'd0, 8'd4, 1, 0, 1'b1, 32'd9, 32'hFFFF_FFFF};
`else
        vz = '{3'b010, 32'd9, 32'd0, 8'd4, 6, 4, 1'b1, 32'd9, 32'hFFFF_FFFF};
`endif
        run_op(vz);

        // reset during MUL cycle 1
        @(posedge clk); #1; op_valid = 1'b1; op = 3'b000; src1 = 32'd5; src2 = 32'd6;
        @(posedge clk); #1; resetn = 1'b0;
        #1;
        check("rstmul_ctrl", {58'd0, stallreq, done, div_start, div_annul, div_signed, mul_signed}, 64'd0);
        check("rstmul_bus", {32'd0, mul_ina | mul_inb | div_opdata1 | div_opdata2}, 64'd0);
        check("rstmul_hilo", {hi, lo}, 64'd0);
        op_valid = 1'b0;
        @(negedge clk); resetn = 1'b1;

        // reset during DIV, then a late div_ready
        div_lat_tb = 8'd20;
        @(posedge clk); #1; op_valid = 1'b1; op = 3'b011; src1 = 32'd77; src2 = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        check("rstdiv_pre", {63'd0, div_start}, 64'd1);
        resetn = 1'b0; op_valid = 1'b0;
        #1;
        check("rstdiv_start", {63'd0, div_start}, 64'd0);
        @(negedge clk); resetn = 1'b1; force_rdy = 1'b1;
        repeat (2) @(negedge clk);
        force_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("rstdiv_hilo", {hi, lo}, 64'd0);

        check("done_count", 64'(done_seen), 64'(pushes));
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
